// File: rtl/execute_mdu.sv
// Multiply/divide unit: fixed-latency MULT/DIV into pending registers, committed to HI/LO on completion.
// Latency MULT_LAT/DIV_LAT busy cycles (MTHI/MTLO: 1 cycle); ops presented while busy are dropped, upstream holds.
module execute_mdu #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] md_a,
  input  logic [WIDTH-1:0] md_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   pend_hi;
  logic [WIDTH-1:0]   pend_lo;
  logic               pend_wr;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;
  logic               a_neg;
  logic               b_neg;
  logic               is_mul;
  logic               is_div;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    a_neg  = (md_op == OP_DIV) && md_a[WIDTH-1];
    b_neg  = (md_op == OP_DIV) && md_b[WIDTH-1];

    // Sign-extending before an unsigned multiply yields the correct signed 2W product.
    if (md_op == OP_MULT)
      prod = {{WIDTH{md_a[WIDTH-1]}}, md_a} * {{WIDTH{md_b[WIDTH-1]}}, md_b};
    else
      prod = {{WIDTH{1'b0}}, md_a} * {{WIDTH{1'b0}}, md_b};

    // Magnitude divide; the most-negative dividend's magnitude is exact as an unsigned value.
    a_mag = a_neg ? -md_a : md_a;
    b_mag = b_neg ? -md_b : md_b;
    if (b_mag == '0)
      b_mag = {{(WIDTH-1){1'b0}}, 1'b1};
    uq = a_mag / b_mag;
    ur = a_mag % b_mag;

    if (is_mul) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      res_hi = a_neg ? -ur : ur;
      res_lo = (a_neg ^ b_neg) ? -uq : uq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
        if (pend_wr) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end else begin
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
      if (is_mul || is_div) begin
        cnt     <= is_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
        busy    <= 1'b1;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= !(is_div && (md_b == '0));
      end else if (md_op == OP_MTHI) begin
        hi <= md_a;
      end else if (md_op == OP_MTLO) begin
        lo <= md_a;
      end
    end
  end

endmodule

// File: tb/tb_execute_mdu.sv
// Directed self-checking bench for execute_mdu at default parameters.
module tb_execute_mdu;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  execute_mdu #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .md_a  (md_a),
    .md_b  (md_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    md_op = 3'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present op for one rising edge; returns at the following negedge with md_op cleared.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_op = op;
    md_a  = a;
    md_b  = b;
    @(negedge clk);
    md_op = 3'd0;
  endtask

  // Counts negedges with busy high; stops at the first negedge where busy is low (bounded).
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    md_op = 3'd0;
    md_a  = '0;
    md_b  = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (hi !== 32'h0)   begin n_err++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
    n_cmp++; if (lo !== 32'h0)   begin n_err++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    // Reset must dominate an op presented with it.
    md_op = 3'd1; md_a = 32'd3; md_b = 32'd3;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_prio_busy got %b want 0", busy); end
    md_op = 3'd0;
    reset = 1'b0;
  endtask

  task automatic test_mult_signed();
    int n;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL mult_pending_hidden got %h want %h", lo, 32'h0); end
    wait_idle(n);
    n_cmp++; if (n !== 5)      begin n_err++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mult_done got %b want 1", done); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo got %h want %h", lo, 32'hFFFF_FFFA); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_once got %b want 0", done); end
  endtask

  task automatic test_multu_div();
    int n;
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    n_cmp++; if (hi !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi got %h want %h", hi, 32'h1); end
    n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo got %h want %h", lo, 32'hFFFF_FFFE); end
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL div_busy_cycles got %0d want 10", n); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h want %h", lo, 32'hFFFF_FFFD); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h want %h", hi, 32'hFFFF_FFFF); end
  endtask

  task automatic test_mthi_divzero();
    int n;
    pulse_reset();
    issue(3'd5, 32'h0000_1234, 32'd0);
    n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL mthi_hi got %h want %h", hi, 32'h1234); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mthi_done got %b want 0", done); end
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    n_cmp++; if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h0)
      begin n_err++; $display("FAIL reserved_op got busy=%b hi=%h lo=%h want 0/00001234/00000000", busy, hi, lo); end
    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL divz_busy_cycles got %0d want 10", n); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL divz_done got %b want 1", done); end
    n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL divz_hi got %h want %h", hi, 32'h1234); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL divz_lo got %h want %h", lo, 32'h0); end
  endtask

  task automatic test_div_overflow();
    int n;
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo got %h want %h", lo, 32'h8000_0000); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi got %h want %h", hi, 32'h0); end
  endtask

  task automatic test_ignore_while_busy();
    int n;
    pulse_reset();
    issue(3'd1, 32'd3, 32'd5);
    md_op = 3'd6; md_a = 32'h55;
    @(negedge clk);
    // Hold a DIV through the rest of busy, including the counter==1 cycle.
    md_op = 3'd3; md_a = 32'd100; md_b = 32'd7;
    wait_idle(n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL ign_busy_cycles got %0d want 4", n); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ign_done got %b want 1", done); end
    n_cmp++; if (lo !== 32'd15) begin n_err++; $display("FAIL ign_lo got %h want %h", lo, 32'd15); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL ign_hi got %h want %h", hi, 32'd0); end
    @(negedge clk);
    md_op = 3'd0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL repres_accept got busy=%b want 1", busy); end
    wait_idle(n);
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL repres_busy_cycles got %0d want 10", n); end
    n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL repres_lo got %h want %h", lo, 32'd14); end
    n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL repres_hi got %h want %h", hi, 32'd2); end
  endtask

  task automatic test_reset_mid_op();
    int late_done;
    issue(3'd3, 32'd9, 32'd2);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL midrst_hilo got hi=%h lo=%h want 0/0", hi, lo); end
    late_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || lo !== 32'h0 || busy !== 1'b0) late_done++;
    end
    n_cmp++; if (late_done !== 0) begin n_err++; $display("FAIL midrst_no_commit got %0d bad cycles want 0", late_done); end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu_div();
    test_mthi_divzero();
    test_div_overflow();
    test_ignore_while_busy();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
